// File: rtl/cube_pkg.sv
// Shared types and helpers for the LED-cube latch bank sequencer.
//   latch_seq_state_t : sequencer FSM state encoding
//   bit_find_t        : result of a next-set-bit search
//   find_next_set     : lowest set bit of vec at an index >= from
package cube_pkg;

    localparam int unsigned MAX_LATCHES = 32;
    localparam int unsigned MAX_IDX_W   = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } latch_seq_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } bit_find_t;

    // Scanning downward lets the lowest qualifying bit win; 'from' may be 32,
    // which yields no match rather than wrapping.
    function automatic bit_find_t find_next_set(input logic [MAX_LATCHES-1:0] vec,
                                                input logic [MAX_IDX_W:0]     from);
        bit_find_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_LATCHES - 1; i >= 0; i--) begin
            if (vec[i] && ((MAX_IDX_W+1)'(i) >= from)) begin
                r.found = 1'b1;
                r.idx   = MAX_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/latch_phase_timer.sv
// Loadable down-counter timing one sequencer phase.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val this cycle (phase entry)
//   load_val  : phase length minus one
//   expired_c : count has reached zero (last cycle of the phase)
module latch_phase_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt_q;

    // Counter saturates at zero until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/latch_bank_sequencer.sv
// Writes a snapshot of NUM_LATCHES words into a bank of octal latch chips over
// one shared data bus, one enabled chip at a time in ascending index order,
// with programmable setup / strobe / hold phases per word.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request a bank write (accepted in IDLE or DONE)
//   frame_in  : NUM_LATCHES packed words, word i at [i*DATA_W +: DATA_W]
//   latch_en  : per-chip write enable, sampled with start
//   data_out  : shared data bus
//   latch_out : one-hot strobe to the chips
//   busy      : high while writing (SETUP/PULSE/HOLD)
//   done      : one-cycle pulse after the bank is written
module latch_bank_sequencer
    import cube_pkg::*;
#(
    parameter int unsigned NUM_LATCHES = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned PULSE_CYC   = 1,
    parameter int unsigned HOLD_CYC    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_LATCHES*DATA_W-1:0] frame_in,
    input  logic [NUM_LATCHES-1:0]        latch_en,
    output logic [DATA_W-1:0]             data_out,
    output logic [NUM_LATCHES-1:0]        latch_out,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned IDX_W   = $clog2(NUM_LATCHES);

    if (NUM_LATCHES < 2 || NUM_LATCHES > MAX_LATCHES ||
        SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_params
        $error("latch_bank_sequencer: illegal parameter values");
    end

    latch_seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_LATCHES-1:0]   en_q, en_d;
    logic [DATA_W-1:0]        snap_q [NUM_LATCHES];
    logic [DATA_W-1:0]        snap_d [NUM_LATCHES];

    logic                     tmr_load;
    logic [CNT_W-1:0]         tmr_val;
    logic                     tmr_expired_c;

    logic [DATA_W-1:0]        data_d;
    logic [NUM_LATCHES-1:0]   latch_d;
    logic                     busy_d;
    logic                     done_d;

    bit_find_t                first_f;
    bit_find_t                next_f;

    latch_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired_c(tmr_expired_c)
    );

    // State, snapshot and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            en_q      <= '0;
            for (int i = 0; i < int'(NUM_LATCHES); i++) begin
                snap_q[i] <= '0;
            end
            data_out  <= '0;
            latch_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            en_q      <= en_d;
            snap_q    <= snap_d;
            data_out  <= data_d;
            latch_out <= latch_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next state, snapshot capture and next-output decode.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        en_d     = en_q;
        snap_d   = snap_q;
        tmr_load = 1'b0;
        tmr_val  = '0;

        first_f = find_next_set(MAX_LATCHES'(latch_en), '0);
        next_f  = find_next_set(MAX_LATCHES'(en_q), (MAX_IDX_W+1)'(idx_q) + (MAX_IDX_W+1)'(1));

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (latch_en != '0) begin
                        en_d = latch_en;
                        for (int i = 0; i < int'(NUM_LATCHES); i++) begin
                            snap_d[i] = frame_in[i*DATA_W +: DATA_W];
                        end
                        idx_d    = IDX_W'(first_f.idx);
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SETUP: begin
                if (tmr_expired_c) begin
                    state_d  = PULSE;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                if (tmr_expired_c) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_expired_c) begin
                    if (next_f.found) begin
                        idx_d    = IDX_W'(next_f.idx);
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next-state values so the registered copies
        // line up with the state they describe.
        busy_d  = (state_d == SETUP) || (state_d == PULSE) || (state_d == HOLD);
        done_d  = (state_d == DONE);
        data_d  = busy_d ? snap_d[idx_d] : '0;
        latch_d = (state_d == PULSE) ? (NUM_LATCHES'(1) << idx_d) : '0;
    end

endmodule

// File: tb/tb_latch_bank_sequencer.sv
module tb_latch_bank_sequencer;

    localparam int unsigned NL = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned SC = 2;
    localparam int unsigned PC = 3;
    localparam int unsigned HC = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NL*DW-1:0] frame_in;
    logic [NL-1:0]    latch_en;
    logic [DW-1:0]    data_out;
    logic [NL-1:0]    latch_out;
    logic             busy;
    logic             done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NL-1:0] latch;
        logic          busy;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t nxt;
    int   n_starts  = 0;
    int   n_dones   = 0;

    always #5 clk = ~clk;

    latch_bank_sequencer #(
        .NUM_LATCHES(NL),
        .DATA_W     (DW),
        .SETUP_CYC  (SC),
        .PULSE_CYC  (PC),
        .HOLD_CYC   (HC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .frame_in (frame_in),
        .latch_en (latch_en),
        .data_out (data_out),
        .latch_out(latch_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference: an accepted start expands into the full per-cycle trace of
    // the bank write, built directly from the phase lengths and enable mask.
    task automatic build_trace(input logic [NL*DW-1:0] frame, input logic [NL-1:0] en);
        exp_t e;
        for (int i = 0; i < int'(NL); i++) begin
            if (en[i]) begin
                e.data = frame[i*DW +: DW];
                e.busy = 1'b1;
                e.done = 1'b0;
                e.latch = '0;
                for (int k = 0; k < int'(SC); k++) exp_q.push_back(e);
                e.latch = '0;
                e.latch[i] = 1'b1;
                for (int k = 0; k < int'(PC); k++) exp_q.push_back(e);
                e.latch = '0;
                for (int k = 0; k < int'(HC); k++) exp_q.push_back(e);
            end
        end
        e = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    int start_pct;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        frame_in = '0;
        latch_en = '0;
        cur      = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  32'(data_out),  32'h0);
        check("reset_latch", 32'(latch_out), 32'h0);
        check("reset_busy",  32'(busy),      32'h0);
        check("reset_done",  32'(done),      32'h0);

        start_pct = 100;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            if (cyc % 300 == 0) begin
                case ($urandom_range(0, 3))
                    0: start_pct = 100;
                    1: start_pct = 30;
                    2: start_pct = 60;
                    default: start_pct = 5;
                endcase
            end
            rst      = (cyc > 20) && ($urandom_range(0, 249) == 0);
            start    = ($urandom_range(1, 100) <= start_pct);
            frame_in = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: latch_en = '0;
                1: latch_en = 8'hFF;
                2: latch_en = 8'b1000_0101;
                default: latch_en = NL'($urandom);
            endcase

            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                nxt = '0;
            end else begin
                if (!cur.busy && start) begin
                    exp_q.delete();
                    build_trace(frame_in, latch_en);
                    n_starts++;
                end
                nxt = (exp_q.size() != 0) ? exp_q.pop_front() : exp_t'('0);
            end

            #1;
            check("data_out",  32'(data_out),  32'(nxt.data));
            check("latch_out", 32'(latch_out), 32'(nxt.latch));
            check("busy",      32'(busy),      32'(nxt.busy));
            check("done",      32'(done),      32'(nxt.done));
            if (done) n_dones++;
            cur = nxt;
        end

        // Every accepted start not cut short by reset yields one done; with
        // rare resets this is a loose sanity bound on activity.
        check("dones_seen", 32'(n_dones > 0), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
